// File: rtl/alu_cmd_issue_pkg.sv
// Shared types for the ALU command issue block: opcode enums, the queued
// command record, issue FSM states and the divide-by-zero decode.
package alu_cmd_issue_pkg;

  typedef enum logic [1:0] {
    ARITH_ADD = 2'd0,
    ARITH_SUB = 2'd1,
    ARITH_MUL = 2'd2,
    ARITH_DIV = 2'd3
  } arith_operation;

  typedef enum logic [1:0] {
    LOGIC_NAND = 2'd0,
    LOGIC_NOR  = 2'd1,
    LOGIC_NOT  = 2'd2,
    LOGIC_XOR  = 2'd3
  } logic_operation;

  // Tag storage is sized for the widest tag the block supports; narrower
  // tags are zero-extended on entry and truncated on exit.
  localparam int MAX_TAG_W = 8;

  typedef struct packed {
    logic                 sel;
    logic [1:0]           op;
    logic [7:0]           data1;
    logic [7:0]           data2;
    logic [MAX_TAG_W-1:0] tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } issue_state_t;

  localparam logic [1:0] DIV_OP = 2'd3;

  function automatic logic is_div_zero(input alu_cmd_t cmd);
    return !cmd.sel && (cmd.op == DIV_OP) && (cmd.data2 == 8'h00);
  endfunction

endpackage

// File: rtl/alu_cmd_issue_fifo.sv
// Small synchronous command FIFO; the head entry is visible combinationally
// so the ALU can be driven in the same cycle the entry is popped.
module alu_cmd_fifo
  import alu_cmd_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push,
  input  alu_cmd_t push_cmd,
  input  logic     pop,
  output alu_cmd_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  alu_cmd_t    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/alu_cmd_issue.sv
// Command front end and result back end around the combinational ALU:
// buffers commands, issues one per cycle and registers the ALU result.
module alu_cmd_issue
  import alu_cmd_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sel,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data1,
  input  logic [7:0]       cmd_data2,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_arith_logic_sel,
  output logic [1:0]       alu_operation,
  output logic [7:0]       alu_ip_data1,
  output logic [7:0]       alu_ip_data2,
  input  logic [15:0]      alu_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic [15:0]      op_count,
  output logic [7:0]       err_count
);

  logic         full;
  logic         empty;
  logic         push;
  logic         issue;
  logic         show_head;
  logic         div_zero;
  logic         unused_head_bits;
  alu_cmd_t     push_cmd;
  alu_cmd_t     head;

  logic             res_valid_reg;
  logic [15:0]      res_data_reg;
  logic [TAG_W-1:0] res_tag_reg;
  logic             res_err_reg;
  logic [15:0]      op_count_reg;
  logic [7:0]       err_count_reg;
  issue_state_t     state_reg;
  issue_state_t     state_next;

  assign cmd_ready = !rst && !flush && !full;
  assign push      = cmd_valid && cmd_ready;
  assign issue     = !rst && !flush && !empty && (!res_valid_reg || res_ready);

  assign push_cmd.sel   = cmd_sel;
  assign push_cmd.op    = cmd_op;
  assign push_cmd.data1 = cmd_data1;
  assign push_cmd.data2 = cmd_data2;
  assign push_cmd.tag   = MAX_TAG_W'(cmd_tag);

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .push_cmd(push_cmd),
    .pop     (issue),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Stale FIFO storage must never reach the ALU pins.
  assign show_head           = !rst && !empty;
  assign alu_arith_logic_sel = show_head && head.sel;
  assign alu_operation       = show_head ? head.op    : 2'b00;
  assign alu_ip_data1        = show_head ? head.data1 : 8'h00;
  assign alu_ip_data2        = show_head ? head.data2 : 8'h00;
  assign div_zero            = is_div_zero(head);
  assign unused_head_bits    = ^head.tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_tag_reg   <= '0;
      res_err_reg   <= 1'b0;
      op_count_reg  <= '0;
      err_count_reg <= '0;
    end else if (flush) begin
      res_valid_reg <= 1'b0;
      res_err_reg   <= 1'b0;
    end else if (issue) begin
      res_valid_reg <= 1'b1;
      res_data_reg  <= div_zero ? 16'h0000 : alu_data_out;
      res_tag_reg   <= head.tag[TAG_W-1:0];
      res_err_reg   <= div_zero;
      op_count_reg  <= op_count_reg + 16'd1;
      if (div_zero && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end else if (res_valid_reg && res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Status-only FSM: it tracks activity but never gates the datapath.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (push) state_next = RUN;
        end
        RUN: begin
          if (res_valid_reg && !res_ready && !empty) begin
            state_next = STALL;
          end else if (empty && (!res_valid_reg || res_ready) && !push) begin
            state_next = IDLE;
          end
        end
        STALL: begin
          if (res_ready) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_tag   = res_tag_reg;
  assign res_err   = res_err_reg;
  assign op_count  = op_count_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: behavioural ALU, queue-based result
// model and one task per scenario.
module tb_alu_cmd_issue;
  import alu_cmd_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_sel;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_data1;
  logic [7:0]       cmd_data2;
  logic [TAG_W-1:0] cmd_tag;
  logic             alu_arith_logic_sel;
  logic [1:0]       alu_operation;
  logic [7:0]       alu_ip_data1;
  logic [7:0]       alu_ip_data2;
  logic [15:0]      alu_data_out;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic [15:0]      op_count;
  logic [7:0]       err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_op(cmd_op), .cmd_data1(cmd_data1), .cmd_data2(cmd_data2),
    .cmd_tag(cmd_tag),
    .alu_arith_logic_sel(alu_arith_logic_sel), .alu_operation(alu_operation),
    .alu_ip_data1(alu_ip_data1), .alu_ip_data2(alu_ip_data2),
    .alu_data_out(alu_data_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err),
    .op_count(op_count), .err_count(err_count)
  );

  // Stand-in for the team ALU; a zero divisor yields junk that must be suppressed.
  function automatic logic [15:0] alu_fn(input logic sel, input logic [1:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
    if (!sel) begin
      case (op)
        2'd0:    return 16'(a) + 16'(b);
        2'd1:    return 16'(a) - 16'(b);
        2'd2:    return 16'(a) * 16'(b);
        default: return (b == 8'h00) ? 16'hDEAD : 16'(a / b);
      endcase
    end
    case (op)
      2'd0:    return {8'h00, ~(a & b)};
      2'd1:    return {8'h00, ~(a | b)};
      2'd2:    return {8'h00, ~a};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  assign alu_data_out = alu_fn(alu_arith_logic_sel, alu_operation, alu_ip_data1, alu_ip_data2);

  // Reference model: every accepted, unconsumed command in order; entry 0 is
  // the visible result whenever m_res_full is set.
  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  int          m_fifo_n = 0;
  bit          m_res_full = 0;
  logic [15:0] m_op = '0;
  logic [7:0]  m_err = '0;

  task automatic set_cmd(input logic sel, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_op    = op;
    cmd_data1 = a;
    cmd_data2 = b;
    cmd_tag   = tag;
  endtask

  task automatic rand_cmd(input logic [TAG_W-1:0] tag);
    if ($urandom_range(3) == 0)
      set_cmd(1'b0, 2'(ARITH_DIV), 8'($urandom), 8'h00, tag);
    else
      set_cmd(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), tag);
  endtask

  // Advance the model by the rules for one clock edge, then step past the edge.
  task automatic tick();
    bit   push, iss, cons;
    exp_t e;
    push = cmd_valid && !rst && !flush && (m_fifo_n < DEPTH);
    iss  = !rst && !flush && (m_fifo_n > 0) && (!m_res_full || res_ready);
    cons = m_res_full && res_ready;
    if (rst) begin
      exp_q.delete(); m_fifo_n = 0; m_res_full = 0; m_op = '0; m_err = '0;
    end else if (flush) begin
      exp_q.delete(); m_fifo_n = 0; m_res_full = 0;
    end else begin
      if (iss) begin
        e = exp_q[m_res_full ? 1 : 0];
        m_op = m_op + 16'd1;
        if (e.err && m_err != 8'hFF) m_err = m_err + 8'd1;
      end
      if (cons) void'(exp_q.pop_front());
      if (push) begin
        e.err  = !cmd_sel && (cmd_op == 2'd3) && (cmd_data2 == 8'h00);
        e.data = e.err ? 16'h0000 : alu_fn(cmd_sel, cmd_op, cmd_data1, cmd_data2);
        e.tag  = cmd_tag;
        exp_q.push_back(e);
      end
      m_res_full = iss || (m_res_full && !res_ready);
      m_fifo_n   = m_fifo_n + (push ? 1 : 0) - (iss ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    set_cmd(1'b0, 2'd0, 8'h00, 8'h00, '0);
    cmd_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({cmd_ready, res_valid, res_err, alu_arith_logic_sel, alu_operation, alu_ip_data1,
         alu_ip_data2, res_data, res_tag, op_count, err_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%0b vld=%0b data=%h ops=%h errs=%h expected all zero",
               cmd_ready, res_valid, res_data, op_count, err_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_release: got %0b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    set_cmd(1'b0, 2'(ARITH_MUL), 8'h10, 8'h10, 4'h5);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_operation !== 2'd2 || alu_ip_data1 !== 8'h10 || alu_ip_data2 !== 8'h10) begin
      failures++;
      $display("FAIL single_alu_pins: got op=%0d d1=%h d2=%h expected op=2 d1=10 d2=10",
               alu_operation, alu_ip_data1, alu_ip_data2);
    end
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL single_early_valid: got %0b expected 0", res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0100 || res_tag !== 4'h5 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got vld=%0b data=%h tag=%h err=%0b expected 1 0100 5 0",
               res_valid, res_data, res_tag, res_err);
    end
    checks++;
    if (op_count !== 16'd1) begin
      failures++; $display("FAIL single_op_count: got %0d expected 1", op_count);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL single_consumed: got %0b expected 0", res_valid);
    end
  endtask

  task automatic test_div_zero();
    res_ready = 1'b1;
    set_cmd(1'b0, 2'(ARITH_DIV), 8'h20, 8'h00, 4'h1);
    tick();
    set_cmd(1'b0, 2'(ARITH_DIV), 8'h20, 8'h04, 4'h2);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_err !== 1'b1 || res_tag !== 4'h1 ||
        err_count !== 8'd1) begin
      failures++;
      $display("FAIL div_zero_result: got vld=%0b data=%h err=%0b tag=%h errs=%0d expected 1 0000 1 1 1",
               res_valid, res_data, res_err, res_tag, err_count);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0008 || res_err !== 1'b0 || res_tag !== 4'h2 ||
        err_count !== 8'd1 || op_count !== 16'd3) begin
      failures++;
      $display("FAIL div_normal_result: got vld=%0b data=%h err=%0b tag=%h errs=%0d ops=%0d expected 1 0008 0 2 1 3",
               res_valid, res_data, res_err, res_tag, err_count, op_count);
    end
    drain();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_cmd(TAG_W'(i));
      #1;
      checks++;
      if (cmd_ready !== (i < 5)) begin
        failures++; $display("FAIL bp_cmd_ready[%0d]: got %0b expected %0b", i, cmd_ready, i < 5);
      end
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (dut.state_reg !== STALL) begin
      failures++; $display("FAIL bp_stall_state: got %0d expected %0d", dut.state_reg, STALL);
    end
    res_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (res_valid !== 1'b1 || res_tag !== TAG_W'(j) || exp_q.size() == 0 ||
          res_data !== exp_q[0].data || res_err !== exp_q[0].err) begin
        failures++;
        $display("FAIL bp_order[%0d]: got vld=%0b tag=%h data=%h expected tag=%h", j, res_valid,
                 res_tag, res_data, j);
      end
      tick();
    end
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL bp_no_duplicate: got vld=%0b expected 0", res_valid);
    end
    drain();
  endtask

  task automatic test_streaming();
    logic [15:0] base;
    base = m_op;
    res_ready = 1'b1;
    for (int k = 0; k < 102; k++) begin
      if (k < 100) rand_cmd(TAG_W'(k)); else cmd_valid = 1'b0;
      #1;
      checks++;
      if (res_valid !== (k >= 2)) begin
        failures++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", k, res_valid, k >= 2);
      end
      if (m_res_full) begin
        checks++;
        if (res_data !== exp_q[0].data || res_tag !== exp_q[0].tag || res_err !== exp_q[0].err) begin
          failures++;
          $display("FAIL stream_data[%0d]: got %h/%h/%0b expected %h/%h/%0b", k, res_data, res_tag,
                   res_err, exp_q[0].data, exp_q[0].tag, exp_q[0].err);
        end
      end
      tick();
    end
    checks++;
    if (op_count !== base + 16'd100) begin
      failures++; $display("FAIL stream_op_count: got %0d expected %0d", op_count, base + 16'd100);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(1) == 1) rand_cmd(TAG_W'($urandom)); else cmd_valid = 1'b0;
      res_ready = ($urandom_range(3) != 0);
      #1;
      checks++;
      if (cmd_ready !== (m_fifo_n < DEPTH) || res_valid !== m_res_full ||
          op_count !== m_op || err_count !== m_err) begin
        failures++;
        $display("FAIL rand_status[%0d]: got rdy=%0b vld=%0b ops=%0d errs=%0d expected %0b %0b %0d %0d",
                 k, cmd_ready, res_valid, op_count, err_count, m_fifo_n < DEPTH, m_res_full, m_op, m_err);
      end
      if (m_res_full) begin
        checks++;
        if (res_data !== exp_q[0].data || res_tag !== exp_q[0].tag || res_err !== exp_q[0].err) begin
          failures++;
          $display("FAIL rand_data[%0d]: got %h/%h/%0b expected %h/%h/%0b", k, res_data, res_tag,
                   res_err, exp_q[0].data, exp_q[0].tag, exp_q[0].err);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_err_saturate();
    res_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      set_cmd(1'b0, 2'(ARITH_DIV), 8'($urandom), 8'h00, TAG_W'(k));
      tick();
    end
    drain();
    checks++;
    if (err_count !== 8'hFF) begin
      failures++; $display("FAIL err_saturate: got %h expected ff", err_count);
    end
    checks++;
    if (op_count !== m_op) begin
      failures++; $display("FAIL err_sat_op_count: got %0d expected %0d", op_count, m_op);
    end
  endtask

  task automatic test_flush();
    logic [15:0] base;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_cmd(TAG_W'(8 + i));
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || m_fifo_n != 3) begin
      failures++; $display("FAIL flush_setup: got vld=%0b expected 1 with 3 queued", res_valid);
    end
    base = m_op;
    flush = 1'b1;
    rand_cmd(4'hE);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL flush_cmd_ready: got %0b expected 0", cmd_ready);
    end
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_err !== 1'b0 || alu_operation !== 2'd0 || alu_ip_data1 !== 8'h00 ||
        alu_ip_data2 !== 8'h00 || cmd_ready !== 1'b1 || op_count !== base) begin
      failures++;
      $display("FAIL flush_cleared: got vld=%0b err=%0b d1=%h rdy=%0b ops=%0d expected 0 0 00 1 %0d",
               res_valid, res_err, alu_ip_data1, cmd_ready, op_count, base);
    end
    checks++;
    if (dut.state_reg !== IDLE) begin
      failures++; $display("FAIL flush_state: got %0d expected %0d", dut.state_reg, IDLE);
    end
    res_ready = 1'b1;
    set_cmd(1'b1, 2'(LOGIC_XOR), 8'h0F, 8'hF0, 4'h7);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_tag !== 4'h7 || res_data !== 16'h00FF) begin
      failures++;
      $display("FAIL flush_recover: got vld=%0b tag=%h data=%h expected 1 7 00ff", res_valid, res_tag, res_data);
    end
    drain();
  endtask

  task automatic test_rst_mid();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_cmd(TAG_W'(i));
      tick();
    end
    rst = 1'b1;
    flush = 1'b1;
    rand_cmd(4'h3);
    tick();
    checks++;
    if ({cmd_ready, res_valid, res_err, alu_arith_logic_sel, alu_operation, alu_ip_data1,
         alu_ip_data2, res_data, res_tag, op_count, err_count} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got ready=%0b vld=%0b data=%h ops=%h errs=%h expected all zero",
               cmd_ready, res_valid, res_data, op_count, err_count);
    end
    rst = 1'b0;
    flush = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || op_count !== 16'd0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid_release: got rdy=%0b vld=%0b ops=%0d errs=%0d expected 1 0 0 0",
               cmd_ready, res_valid, op_count, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_div_zero();
    test_backpressure();
    test_streaming();
    test_random();
    test_err_saturate();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Sequential front/back end for the team's combinational arithmetic/logic unit.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues at most one command per cycle onto the ALU input pins, then registers the ALU's 16-bit output into a result stage with its own valid/ready handshake.
- Flags and counts divide-by-zero commands, and supports a synchronous flush.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- TAG_W, 4: width of the user tag carried from command to result.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO and result stage; counters are kept.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_sel  input  1  0 = arithmetic, 1 = logic.
- cmd_op  input  2  arith: add/sub/mul/div = 0..3; logic: nand/nor/not/xor = 0..3.
- cmd_data1, cmd_data2  input  8  operands.
- cmd_tag  input  TAG_W  returned unchanged with the result.
- alu_arith_logic_sel  output  1  to ALU.
- alu_operation  output  2  to ALU.
- alu_ip_data1, alu_ip_data2  output  8  to ALU.
- alu_data_out  input  16  from ALU, combinational response to the alu_* outputs.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts when res_valid && res_ready.
- res_data  output  16  captured result.
- res_tag  output  TAG_W  tag of that result.
- res_err  output  1  result is a suppressed divide-by-zero.
- op_count  output  16  commands completed; wraps at 16'hFFFF -> 0.
- err_count  output  8  divide-by-zero count; saturates at 8'hFF.

Behaviour:
- Reset (rst=1): every output is 0, FIFO is empty, FSM is in IDLE. Exception: cmd_ready rises to 1 in the first cycle after rst deasserts.
- rst has priority over flush, and flush has priority over all handshakes.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits and wrap naturally.
  - cmd_ready = !full && !flush.
  - A push while full is impossible: cmd_ready is low, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count is unchanged and both operations take effect.
- Issue condition: issue = !empty && (!res_valid || res_ready).
- alu_* outputs:
  - Driven combinationally from the FIFO head entry.
  - Forced to 0 when the FIFO is empty.
- On issue:
  - FIFO head pops.
  - res_data <= alu_data_out, res_tag <= head tag, res_valid <= 1.
  - op_count increments.
- Divide-by-zero (head sel=0, op=3, data2=0):
  - res_data <= 16'h0000 and res_err <= 1; the ALU output is ignored.
  - err_count increments, saturating.
  - All other commands set res_err <= 0.
- Result stage:
  - If res_valid && res_ready and there is no issue in the same cycle, res_valid <= 0.
  - While res_valid && !res_ready, res_data, res_tag and res_err hold stable.
- Latency and throughput:
  - A command accepted in cycle N yields res_valid in cycle N+2 at the earliest.
  - Sustained throughput is 1 per cycle when res_ready is held high.
- FSM, 2-bit encoding:
  - IDLE (empty, !res_valid) -> RUN on a FIFO push.
  - RUN (issuing or result draining) -> STALL when res_valid && !res_ready && !empty.
  - RUN -> IDLE when empty and the result is consumed or absent.
  - STALL -> RUN when res_ready.
  - Any state -> IDLE on flush or rst.
- Flush:
  - Empties the FIFO and clears res_valid and res_err.
  - Any in-flight command is discarded without counting.
  - cmd_ready is 0 during the flush cycle.

Decomposition:
- Shared package:
  - Existing arith_operation and logic_operation enums, reused for decoding.
  - New packed struct alu_cmd_t {sel, op[1:0], data1[7:0], data2[7:0], tag}.
  - Enum issue_state_t {IDLE, RUN, STALL}.
  - Constant DIV_OP = 2'd3.
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO storing alu_cmd_t, with push/pop/full/empty/flush ports.

Test Plan:
- Single command, bench wires the team ALU, res_ready=1: mul 8'h10 x 8'h10, tag 4'h5 pushed in cycle 0 -> cycle 2 shows res_valid=1, res_data=16'h0100, res_tag=5, res_err=0, op_count=1.
- Divide by zero: sel=0, op=3, data1=8'h20, data2=8'h00 -> res_data=16'h0000, res_err=1, err_count=1; the following div 8'h20/8'h04 has res_err=0.
- Backpressure and full:
  - Hold res_ready=0 and push 6 commands.
  - Expected: cmd_ready falls after the 5th accept (DEPTH=4 plus 1 in the result stage) and the FSM reports STALL.
  - Then release res_ready: tags emerge in order 0..4 on consecutive cycles with no loss or duplication.
- Streaming: 100 back-to-back random commands with res_ready=1 -> one result per cycle after the 2-cycle fill and op_count=100. With err_count preloaded by 300 div-by-zero commands, it reads 8'hFF.
- Flush and reset mid-operation:
  - Flush with 3 entries queued and res_valid=1 -> next cycle empty, res_valid=0, op_count unchanged.
  - rst asserted simultaneously with flush and cmd_valid -> all outputs 0 next cycle.
